bpsk_frame_sync_ctrl: RTL
=========================

BPSK_FRAME_SYNC_CTRL -- requirements
Module: bpsk_frame_sync_ctrl

Interface
REQ-001 Parameter SYNC_WORD, default 16'hD391: 16-bit frame sync pattern, MSB received first.
REQ-002 Parameter SYNC_TOL, default 1: maximum bit mismatches (Hamming distance) accepted as a sync hit; range 0..3.
REQ-003 Parameter PAYLOAD_BYTES, default 8: bytes captured per frame after sync; range 1..255.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high = run; low = force HUNT and clear the shift register.
REQ-007 bit_in  input  1  hard-decision bit from the BPSK demodulator.
REQ-008 bit_valid  input  1  one-cycle strobe; bit_in is sampled only when high.
REQ-009 byte_out  output  8  captured payload byte, MSB = first received bit.
REQ-010 byte_valid  output  1  byte_out holds an unconsumed byte.
REQ-011 byte_ready  input  1  consumer accepts byte_out when byte_valid && byte_ready.
REQ-012 frame_start  output  1  one-cycle pulse on sync detection.
REQ-013 frame_done  output  1  one-cycle pulse when the final payload byte is loaded into byte_out.
REQ-014 frame_abort  output  1  one-cycle pulse when enable falls during PAYLOAD.
REQ-015 overflow  output  1  sticky flag: a completed byte was dropped; cleared only by reset.
REQ-016 busy  output  1  high while state is PAYLOAD.

Function
REQ-017 The FSM SHALL have two states, HUNT and PAYLOAD.
REQ-018 In HUNT, each accepted bit SHALL shift into a 16-bit register, LSB end, with no further action.
REQ-019 In HUNT, a hit SHALL occur when the updated register differs from SYNC_WORD in <= SYNC_TOL bits. Only bits accepted since entering HUNT count, so at least 16 bits are required.
REQ-020 On a hit, the block SHALL move to PAYLOAD and pulse frame_start in the cycle after the strobe that carried the last sync bit. It SHALL clear the bit counter (3 bits) and the byte counter (8 bits).
REQ-021 In PAYLOAD, accepted bits SHALL assemble MSB-first into a byte buffer.
REQ-022 Byte load rule: on the 8th bit of a byte, byte_out and byte_valid SHALL update in the following cycle (latency 1 clk from the bit_valid edge).
REQ-023 If byte_valid && !byte_ready when a new byte completes, the new byte SHALL be discarded, the held byte retained, and overflow set. The byte counter SHALL still advance.
REQ-024 If byte_valid && byte_ready coincides with a new byte completing, the new byte SHALL be loaded with no overflow.
REQ-025 byte_valid SHALL drop the cycle after the handshake unless a new byte loads in that same cycle.
REQ-026 When the byte counter reaches PAYLOAD_BYTES, the block SHALL pulse frame_done coincident with the last byte_valid rise (or with the drop, if overflow). It SHALL then return to HUNT with the shift register cleared and re-arm the 16-bit fill requirement.
REQ-027 When enable is low, the FSM SHALL go to HUNT next cycle and the partial byte SHALL be discarded; frame_abort SHALL pulse if the state was PAYLOAD. A pending byte_valid SHALL remain until consumed.
REQ-028 bit_valid while enable is low SHALL be ignored.
REQ-029 The counters SHALL never wrap within a frame; the byte counter SHALL saturate at PAYLOAD_BYTES before the transition.

Reset
REQ-030 While rst_n is low, all outputs SHALL be 0 and state SHALL be HUNT; shift register, counters, buffer and overflow SHALL be cleared.
REQ-031 Reset assertion mid-frame SHALL abort immediately with no frame_abort or frame_done pulse.
REQ-032 Reset deassertion SHALL be used synchronously to clk.

Configuration
REQ-033 Macro BPSK_SYNC_INVERT_DETECT_EN resolves the BPSK 180-degree phase ambiguity.
- When defined: a match against ~SYNC_WORD (<= SYNC_TOL mismatches) SHALL also count as a hit and SHALL set an internal invert flag. All payload bits of that frame SHALL be inverted before assembly. The flag clears on return to HUNT.
- When not defined: only SYNC_WORD SHALL match, and no inversion logic SHALL be synthesised.

Verification
REQ-034 Clean sync: enable=1; 16 bits of 16'hD391, then bytes 0x01..0x08 -> frame_start 1 clk after the 16th bit; bytes 0x01..0x08 in order; frame_done with 0x08; overflow=0.
REQ-035 Tolerance: send 16'hD390 (1 error) -> hit. Send 16'hD392 (2 errors, SYNC_TOL=1) -> no frame_start.
REQ-036 Backpressure: byte_ready=0 for the whole frame -> byte_out stays 0x01, overflow=1, frame_done still pulses after the 8th byte.
REQ-037 Abort: drop enable after 3 payload bytes -> frame_abort pulse, busy=0 next cycle. Re-enable and send a fresh sync -> new frame_start.
REQ-038 Invert (macro defined): send ~16'hD391, then payload 0xFE -> byte_out=0x01. With the macro undefined, the same stimulus -> no frame_start.
REQ-039 Reset mid-frame: assert rst_n=0 during byte 4 -> all outputs 0 immediately, with no frame_done.

Source files
------------

// File: rtl/bpsk_frame_sync_ctrl.sv
// ---------------------------------------------------------------------------
// bpsk_frame_sync_ctrl
//
// Frame synchroniser for a hard-decision BPSK bit stream. It hunts for a
// 16-bit sync word, accepting up to SYNC_TOL bit errors. After a hit it
// assembles PAYLOAD_BYTES bytes MSB-first and presents each byte on a
// valid/ready output. A completed byte is dropped, and the sticky overflow
// flag set, when the previous byte is still held. The block then returns to
// HUNT and needs a fresh 16-bit fill before the next hit.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       run; low forces HUNT and drops any partial byte
//   bit_in       demodulated bit, sampled when bit_valid is high
//   bit_valid    single-cycle bit strobe
//   byte_out     payload byte, MSB = first received bit
//   byte_valid   byte_out holds an unconsumed byte
//   byte_ready   consumer accepts byte_out when byte_valid && byte_ready
//   frame_start  pulse, sync detected
//   frame_done   pulse, final payload byte of the frame completed
//   frame_abort  pulse, enable dropped while in PAYLOAD
//   overflow     sticky, a completed byte was dropped (cleared by reset only)
//   busy         state is PAYLOAD
//
// Build option
//   BPSK_SYNC_INVERT_DETECT_EN  also accept ~SYNC_WORD as a hit and invert
//                               the payload bits of that frame (resolves the
//                               180-degree carrier phase ambiguity)
//
// state   | meaning
// --------+------------------------------------------------------------
// HUNT    | shift accepted bits and compare the window against the sync word
// PAYLOAD | assemble payload bytes until PAYLOAD_BYTES have completed
// ---------------------------------------------------------------------------
module bpsk_frame_sync_ctrl #(
  parameter logic [15:0] SYNC_WORD     = 16'hD391,
  parameter int          SYNC_TOL      = 1,
  parameter int          PAYLOAD_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic {HUNT = 1'b0, PAYLOAD = 1'b1} state_t;

  localparam logic [4:0] TOL    = 5'(SYNC_TOL);
  localparam logic [7:0] NBYTES = 8'(PAYLOAD_BYTES);

  state_t      state;
  logic [15:0] shift_reg;
  logic [3:0]  fill_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [7:0]  byte_buf;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  logic [15:0] shift_nxt;
  logic        filled;
  logic        hit_true;
  logic        hit_any;
  logic        pay_bit;
  logic [7:0]  byte_nxt;
  logic [7:0]  byte_cnt_inc;

  assign shift_nxt = {shift_reg[14:0], bit_in};
  // fill_cnt saturates at 15: together with the bit arriving now that makes 16.
  assign filled    = (fill_cnt == 4'd15);
  assign hit_true  = filled && (popcount16(shift_nxt ^ SYNC_WORD) <= TOL);

`ifdef BPSK_SYNC_INVERT_DETECT_EN
  logic invert;
  logic hit_inv;

  assign hit_inv = filled && (popcount16(shift_nxt ^ ~SYNC_WORD) <= TOL);
  assign hit_any = hit_true || hit_inv;
  assign pay_bit = bit_in ^ invert;

  // Recomputed every HUNT cycle, so it is only set on an inverted hit and
  // clears again one cycle after the return to HUNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invert <= 1'b0;
    end else if (!enable) begin
      invert <= 1'b0;
    end else if (state == HUNT) begin
      invert <= bit_valid && hit_inv && !hit_true;
    end
  end
`else
  assign hit_any = hit_true;
  assign pay_bit = bit_in;
`endif

  assign byte_nxt     = {byte_buf[6:0], pay_bit};
  assign byte_cnt_inc = (byte_cnt == NBYTES) ? byte_cnt : byte_cnt + 8'd1;
  assign busy         = (state == PAYLOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shift_reg   <= '0;
      fill_cnt    <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      byte_buf    <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;

      // Handshake drop; a byte loading in this same cycle overrides it below.
      if (byte_valid && byte_ready) byte_valid <= 1'b0;

      if (!enable) begin
        state       <= HUNT;
        shift_reg   <= '0;
        fill_cnt    <= '0;
        bit_cnt     <= '0;
        byte_buf    <= '0;
        frame_abort <= (state == PAYLOAD);
      end else if (bit_valid) begin
        case (state)
          HUNT: begin
            shift_reg <= shift_nxt;
            if (!filled) fill_cnt <= fill_cnt + 4'd1;
            if (hit_any) begin
              state       <= PAYLOAD;
              frame_start <= 1'b1;
              bit_cnt     <= '0;
              byte_cnt    <= '0;
              byte_buf    <= '0;
            end
          end
          PAYLOAD: begin
            if (bit_cnt == 3'd7) begin
              bit_cnt  <= '0;
              byte_buf <= '0;
              byte_cnt <= byte_cnt_inc;
              if (!byte_valid || byte_ready) begin
                byte_out   <= byte_nxt;
                byte_valid <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
              if (byte_cnt_inc == NBYTES) begin
                state      <= HUNT;
                frame_done <= 1'b1;
                shift_reg  <= '0;
                fill_cnt   <= '0;
              end
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              byte_buf <= byte_nxt;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
